// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: serial configuration loader for the PAL fuse array.
//
// Bits arrive LSB-first over a valid/ready handshake into a shadow shift
// register. When the word is complete, it is copied in one step into the
// active register that drives the PAL planes. The planes therefore keep
// evaluating the old configuration until the new one is committed.
//
// Optional feature (macro PAL_CFG_PARITY_EN): one trailing even-parity bit is
// accepted after the data bits. If the parity check fails, cfg_err is set and
// nothing is committed. When the macro is undefined, cfg_err is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   cfg_start    one-cycle pulse that starts or restarts a load
//   cfg_bit      serial data bit
//   cfg_valid    cfg_bit is valid this cycle
//   cfg_ready    loader accepts a bit this cycle (SHIFT / PARITY)
//   cfg_busy     load in progress (state != IDLE)
//   cfg_done     one-cycle pulse, high in the first cycle the new word is visible
//   cfg_err      sticky parity error (cleared by cfg_start or reset)
//   fuses_out    active fuse word driving the PAL planes
//   fuses_valid  fuses_out holds a committed configuration

module pal_cfg_loader #(
    parameter int unsigned FUSE_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_bit,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic [FUSE_BITS-1:0] fuses_out,
    output logic                 fuses_valid
);

    localparam int unsigned      CNT_W    = $clog2(FUSE_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FUSE_BITS - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2,
        StCommit = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [FUSE_BITS-1:0] shadow_q, shadow_d;
    logic [FUSE_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 fvalid_q, fvalid_d;
    logic                 done_q, done_d;
`ifdef PAL_CFG_PARITY_EN
    logic                 par_q, par_d;
    logic                 err_q, err_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            fvalid_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef PAL_CFG_PARITY_EN
            par_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            fvalid_q <= fvalid_d;
            done_q   <= done_d;
`ifdef PAL_CFG_PARITY_EN
            par_q    <= par_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        cnt_d     = cnt_q;
        fvalid_d  = fvalid_q;
        done_d    = 1'b0;
        cfg_ready = 1'b0;
`ifdef PAL_CFG_PARITY_EN
        par_d     = par_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    state_d = StShift;
                    cnt_d   = '0;
`ifdef PAL_CFG_PARITY_EN
                    par_d   = 1'b0;
                    err_d   = 1'b0;
`endif
                end
            end
            StShift: begin
                cfg_ready = 1'b1;
                if (cfg_start) begin
                    // Restart: the bit presented alongside cfg_start is dropped.
                    cnt_d = '0;
`ifdef PAL_CFG_PARITY_EN
                    par_d = 1'b0;
`endif
                end else if (cfg_valid) begin
                    shadow_d = {cfg_bit, shadow_q[FUSE_BITS-1:1]};
                    cnt_d    = cnt_q + CNT_W'(1);
`ifdef PAL_CFG_PARITY_EN
                    par_d    = par_q ^ cfg_bit;
                    if (cnt_q == LAST_CNT) state_d = StParity;
`else
                    if (cnt_q == LAST_CNT) state_d = StCommit;
`endif
                end
            end
`ifdef PAL_CFG_PARITY_EN
            StParity: begin
                cfg_ready = 1'b1;
                if (cfg_start) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end else if (cfg_valid) begin
                    if ((par_q ^ cfg_bit) == 1'b0) begin
                        state_d = StCommit;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
`endif
            StCommit: begin
                active_d = shadow_q;
                fvalid_d = 1'b1;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign cfg_busy    = (state_q != StIdle);
    assign cfg_done    = done_q;
    assign fuses_out   = active_q;
    assign fuses_valid = fvalid_q;
`ifdef PAL_CFG_PARITY_EN
    assign cfg_err     = err_q;
`else
    assign cfg_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed self-checking bench for pal_cfg_loader with FUSE_BITS=8.
// Inputs change 1 ns after the rising edge, and outputs are sampled there as well.

module tb_pal_cfg_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_err;
    logic [7:0] fuses_out;
    logic       fuses_valid;

    int checks = 0;
    int failures = 0;
    logic [7:0] word;

    pal_cfg_loader #(.FUSE_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_bit    (cfg_bit),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .fuses_out  (fuses_out),
        .fuses_valid(fuses_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        cfg_valid = 1'b1;
        cfg_bit   = b;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", cfg_ready); end
        checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", cfg_busy); end
        checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", cfg_done); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", cfg_err); end
        checks++; if (fuses_out !== 8'h00) begin failures++; $display("FAIL rst_fuses got=%h exp=00", fuses_out); end
        checks++; if (fuses_valid !== 1'b0) begin failures++; $display("FAIL rst_fvalid got=%b exp=0", fuses_valid); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        pulse_start();
        checks++; if (cfg_ready !== 1'b1 || cfg_busy !== 1'b1) begin failures++; $display("FAIL b2b_shift ready=%b busy=%b exp=1,1", cfg_ready, cfg_busy); end
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = word[i];
            tick();
        end
`ifdef PAL_CFG_PARITY_EN
        checks++; if (cfg_ready !== 1'b1 || cfg_busy !== 1'b1) begin failures++; $display("FAIL b2b_parity_state ready=%b busy=%b exp=1,1", cfg_ready, cfg_busy); end
        cfg_bit = 1'b0;
        tick();
`endif
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0 || cfg_busy !== 1'b1) begin failures++; $display("FAIL b2b_commit ready=%b busy=%b exp=0,1", cfg_ready, cfg_busy); end
        checks++; if (cfg_done !== 1'b0 || fuses_out !== 8'h00) begin failures++; $display("FAIL b2b_pre_commit done=%b fuses=%h exp=0,00", cfg_done, fuses_out); end
        tick();
        checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", cfg_done); end
        checks++; if (fuses_out !== 8'h8D) begin failures++; $display("FAIL b2b_fuses got=%h exp=8d", fuses_out); end
        checks++; if (fuses_valid !== 1'b1) begin failures++; $display("FAIL b2b_fvalid got=%b exp=1", fuses_valid); end
        checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_fall got=%b exp=0", cfg_busy); end
        tick();
        checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL b2b_done_width got=%b exp=0", cfg_done); end
        checks++; if (fuses_out !== 8'h8D) begin failures++; $display("FAIL b2b_fuses_hold got=%h exp=8d", fuses_out); end
    endtask

    task automatic test_restart();
        int dones = 0;
        pulse_start();
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        checks++; if (fuses_out !== 8'h8D) begin failures++; $display("FAIL rs_shadow got=%h exp=8d", fuses_out); end
        // Restart; the 0 bit presented alongside the start must be discarded.
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b0;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cfg_bit = 1'b1;
            tick();
            if (cfg_done === 1'b1) dones++;
            if (i == 4) begin
                checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rs_count_cleared ready=%b exp=1", cfg_ready); end
            end
            if (i < 7) begin
                checks++; if (fuses_out !== 8'h8D) begin failures++; $display("FAIL rs_hold_%0d got=%h exp=8d", i, fuses_out); end
            end
        end
`ifdef PAL_CFG_PARITY_EN
        cfg_bit = 1'b0;
        tick();
`endif
        cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cfg_done === 1'b1) dones++;
        end
        checks++; if (dones != 1) begin failures++; $display("FAIL rs_done_count got=%0d exp=1", dones); end
        checks++; if (fuses_out !== 8'hFF) begin failures++; $display("FAIL rs_fuses got=%h exp=ff", fuses_out); end
    endtask

    task automatic test_gapped();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b0;
            cfg_bit   = ~word[i];
            tick();
            checks++; if (cfg_ready !== 1'b1 || cfg_busy !== 1'b1) begin failures++; $display("FAIL gap_ready_%0d ready=%b busy=%b exp=1,1", i, cfg_ready, cfg_busy); end
            send_bit(word[i]);
        end
`ifdef PAL_CFG_PARITY_EN
        tick();
        send_bit(1'b0);
`endif
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL gap_commit ready=%b exp=0", cfg_ready); end
        tick();
        checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL gap_done got=%b exp=1", cfg_done); end
        checks++; if (fuses_out !== 8'h8D) begin failures++; $display("FAIL gap_fuses got=%h exp=8d", fuses_out); end
        tick();
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        for (int i = 0; i < 4; i++) send_bit(word[i]);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (fuses_out !== 8'h00) begin failures++; $display("FAIL rml_fuses got=%h exp=00", fuses_out); end
        checks++; if (fuses_valid !== 1'b0) begin failures++; $display("FAIL rml_fvalid got=%b exp=0", fuses_valid); end
        checks++; if (cfg_busy !== 1'b0 || cfg_ready !== 1'b0) begin failures++; $display("FAIL rml_idle busy=%b ready=%b exp=0,0", cfg_busy, cfg_ready); end
        tick();
        rst = 1'b0;
        tick();
        send_bit(1'b1);
        checks++; if (cfg_busy !== 1'b0 || cfg_ready !== 1'b0) begin failures++; $display("FAIL rml_ignore busy=%b ready=%b exp=0,0", cfg_busy, cfg_ready); end
    endtask

`ifdef PAL_CFG_PARITY_EN
    task automatic test_parity();
        pulse_start();
        for (int i = 0; i < 8; i++) send_bit(word[i]);
        send_bit(1'b1);
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL par_err got=%b exp=1", cfg_err); end
        checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL par_err_idle got=%b exp=0", cfg_busy); end
        tick();
        checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL par_no_done got=%b exp=0", cfg_done); end
        checks++; if (fuses_out !== 8'h00 || fuses_valid !== 1'b0) begin failures++; $display("FAIL par_no_commit fuses=%h fvalid=%b exp=00,0", fuses_out, fuses_valid); end
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL par_err_sticky got=%b exp=1", cfg_err); end
        pulse_start();
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL par_err_clear got=%b exp=0", cfg_err); end
        for (int i = 0; i < 8; i++) send_bit(word[i]);
        send_bit(1'b0);
        tick();
        checks++; if (cfg_done !== 1'b1 || fuses_out !== 8'h8D) begin failures++; $display("FAIL par_ok done=%b fuses=%h exp=1,8d", cfg_done, fuses_out); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL par_ok_err got=%b exp=0", cfg_err); end
    endtask
`endif

    initial begin
        word = 8'h8D;
        test_reset();
        test_back_to_back();
        test_restart();
        test_gapped();
        test_reset_mid_load();
`ifdef PAL_CFG_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
